// File: rtl/route_distributor_pkg.sv
// Shared sizing for the capacitor-slot route distributor.
// Defaults: 4-bit lanes, 35 channels, 70 capacitor slots.
package route_distributor_pkg;

    localparam int WIDTH_DEF         = 4;
    localparam int CHANNEL_NUM_DEF   = 35;
    localparam int CAPACITOR_NUM_DEF = 70;

    // A rank can reach CAPACITOR_NUM when every slot below it is enabled.
    function automatic int rank_width(input int capacitor_num);
        return $clog2(capacitor_num + 1);
    endfunction

endpackage

// File: rtl/route_distributor_sw_rank.sv
// Prefix popcount over the slot enable mask.
// rank(j) counts the set bits below slot j; valid marks slots that receive a lane.
module sw_rank
    import route_distributor_pkg::*;
#(
    parameter int CHANNEL_NUM   = CHANNEL_NUM_DEF,
    parameter int CAPACITOR_NUM = CAPACITOR_NUM_DEF,
    parameter int RANK_W        = rank_width(CAPACITOR_NUM)
) (
    input  logic [CAPACITOR_NUM-1:0]        sw,
    output logic [RANK_W*CAPACITOR_NUM-1:0] rank,
    output logic [CAPACITOR_NUM-1:0]        valid
);

    localparam logic [RANK_W-1:0] RANK_LIM = RANK_W'(CHANNEL_NUM);

    logic [RANK_W-1:0] count;

    always_comb begin
        count = '0;
        rank  = '0;
        valid = '0;
        for (int j = 0; j < CAPACITOR_NUM; j++) begin
            rank[RANK_W*j +: RANK_W] = count;
            // Enabled slots beyond the last channel stay idle.
            valid[j] = sw[j] && (count < RANK_LIM);
            count    = count + RANK_W'(sw[j]);
        end
    end

endmodule

// File: rtl/route_distributor.sv
// Registered crossbar: the k-th enabled capacitor slot (from the LSB) takes input lane k.
// Routing is combinational into a single output register bank; latency is one cycle.
module route_distributor
    import route_distributor_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEF,
    parameter int CHANNEL_NUM   = CHANNEL_NUM_DEF,
    parameter int CAPACITOR_NUM = CAPACITOR_NUM_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WIDTH*CHANNEL_NUM-1:0]   data_in,
    input  logic [CAPACITOR_NUM-1:0]       sw,
    output logic [WIDTH*CAPACITOR_NUM-1:0] data_out_FF
);

    localparam int RANK_W = rank_width(CAPACITOR_NUM);

    logic [RANK_W*CAPACITOR_NUM-1:0] rank;
    logic [CAPACITOR_NUM-1:0]        valid;
    logic [WIDTH*CAPACITOR_NUM-1:0]  data_nxt;

    sw_rank #(
        .CHANNEL_NUM   (CHANNEL_NUM),
        .CAPACITOR_NUM (CAPACITOR_NUM),
        .RANK_W        (RANK_W)
    ) u_sw_rank (
        .sw    (sw),
        .rank  (rank),
        .valid (valid)
    );

    // Per-slot lane mux, written as a compare-select so no index can fall outside the lane range.
    always_comb begin
        data_nxt = '0;
        for (int j = 0; j < CAPACITOR_NUM; j++) begin
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                if (valid[j] && (rank[RANK_W*j +: RANK_W] == RANK_W'(i))) begin
                    data_nxt[WIDTH*j +: WIDTH] = data_in[WIDTH*i +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_FF <= '0;
        end else begin
            data_out_FF <= data_nxt;
        end
    end

endmodule

// File: tb/tb_route_distributor.sv
// Scoreboarded bench for route_distributor: the stimulus thread queues expected captures,
// and a monitor compares one entry per rising edge.
module tb_route_distributor;

    localparam int W   = 4;
    localparam int CH  = 35;
    localparam int CAP = 70;
    localparam int DW  = W * CH;
    localparam int OW  = W * CAP;

    localparam logic [DW-1:0] INIT_DATA = {64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 12'hFED};

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DW-1:0]  data_in;
    logic [CAP-1:0] sw;
    logic [OW-1:0]  data_out_FF;

    logic [OW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic [CAP-1:0] low_half, high_half, alt_bits, all_ones, five;

    route_distributor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .sw          (sw),
        .data_out_FF (data_out_FF)
    );

    always #5 clk = ~clk;

    // Lanes are handed out to enabled slots in order of the enabled slot positions.
    function automatic logic [OW-1:0] model(input logic [DW-1:0] d, input logic [CAP-1:0] s);
        int pos[$];
        logic [OW-1:0] r;
        r = '0;
        for (int j = 0; j < CAP; j++) if (s[j]) pos.push_back(j);
        for (int k = 0; k < pos.size() && k < CH; k++) r[W*pos[k] +: W] = d[W*k +: W];
        return r;
    endfunction

    function automatic logic [CAP-1:0] rand_sw();
        logic [95:0] a, b;
        a = {$urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       return a[CAP-1:0] & b[CAP-1:0];
            1:       return a[CAP-1:0] | b[CAP-1:0];
            default: return a[CAP-1:0];
        endcase
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [CAP-1:0] sw_val);
        @(negedge clk);
        sw      = sw_val;
        data_in = {data_in[3:0], data_in[DW-1:4]};
        exp_q.push_back(model(data_in, sw));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) check("scoreboard", data_out_FF, exp_q.pop_front());
        end
    end

    initial begin
        low_half  = '0;
        high_half = '0;
        alt_bits  = '0;
        for (int j = 0; j < CAP; j++) begin
            if (j < CH) low_half[j] = 1'b1;
            else        high_half[j] = 1'b1;
            alt_bits[j] = (j % 2 == 0);
        end
        all_ones = '1;
        five     = CAP'(5);

        data_in = INIT_DATA;
        sw      = rand_sw();
        rst_n   = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("reset_hold", data_out_FF, '0);
            data_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
            sw      = rand_sw();
        end

        @(negedge clk);
        data_in = INIT_DATA;
        sw      = low_half;
        rst_n   = 1'b1;
        exp_q.push_back(model(data_in, sw));
        @(posedge clk);
        #2;
        check("first_capture_slot1_slot0", OW'(data_out_FF[7:0]), OW'(8'hED));

        repeat (150) drive(low_half);
        repeat (40)  drive(high_half);
        repeat (40)  drive(alt_bits);
        repeat (40)  drive(all_ones);

        // Mid-stream reset: nothing is queued for the edge that falls inside it.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", data_out_FF, '0);
        @(posedge clk);
        #1;
        check("reset_hold_mid", data_out_FF, '0);
        @(negedge clk);
        rst_n = 1'b1;
        sw    = all_ones;
        exp_q.push_back(model(data_in, sw));

        repeat (20)  drive(five);
        repeat (10)  drive('0);
        repeat (300) drive(rand_sw());

        for (int c = 0; c < 5 && exp_q.size() > 0; c++) begin
            @(posedge clk);
            #2;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
